// File: rtl/matrix_pkg.sv
// Shared matrix types for the coordinator, receive path and transmit sequencer.
// Fixed-point part width, complex/matrix containers, byte counts and sequencer states.
package matrix_pkg;

   typedef logic signed [36:0] fixed_t;

   typedef struct packed {
      fixed_t im;
      fixed_t re;
   } complex_t;

   typedef complex_t matrix_t [0:1][0:1];

   localparam int BYTES_PER_NUM = 5;
   localparam int MATRIX_BYTES  = 2 * 2 * 2 * BYTES_PER_NUM;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_FINISH
   } tx_state_t;

endpackage

// File: rtl/matrix_byte_mux.sv
// Maps a stream byte index onto the captured matrix: selects the part, sign-extends it
// and returns the requested byte (LSB first). Indices past the data return 0.
module matrix_byte_mux #(
   parameter int ROWS          = 2,
   parameter int COLS          = 2,
   parameter int WIDTH         = 37,
   parameter int BYTES_PER_NUM = 5,
   parameter int IDX_W         = 6
) (
   input  logic [IDX_W-1:0]              byte_idx,
   input  logic [ROWS*COLS*2*WIDTH-1:0]  matrix,
   output logic [7:0]                    data_byte
);

   localparam int NUM_PARTS = ROWS * COLS * 2;
   localparam int EXT_W     = BYTES_PER_NUM * 8;

   logic signed [WIDTH-1:0] part;
   logic signed [EXT_W-1:0] part_ext;
   int unsigned             part_num;
   int unsigned             byte_num;

   always_comb begin
      part_num  = 32'(byte_idx) / BYTES_PER_NUM;
      byte_num  = 32'(byte_idx) % BYTES_PER_NUM;
      part      = '0;
      part_ext  = '0;
      data_byte = '0;
      if (part_num < NUM_PARTS) begin
         part      = matrix[part_num*WIDTH +: WIDTH];
         part_ext  = EXT_W'(part);
         data_byte = part_ext[byte_num*8 +: 8];
      end
   end

endmodule

// File: rtl/matrix_tx_sequencer.sv
// Streams a captured 2x2 complex matrix to the UART, one byte per SEND/GAP pair.
// Optional trailing XOR checksum byte when MATRIX_TX_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; captures matrix and clears index
// SEND   | offering transmit_byte; pulse transmit_ready when UART available
// GAP    | one dead cycle while the UART drops transmit_available
// FINISH | one-cycle done pulse, then back to IDLE
module matrix_tx_sequencer #(
   parameter int ROWS          = 2,
   parameter int COLS          = 2,
   parameter int WIDTH         = 37,
   parameter int BYTES_PER_NUM = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [ROWS*COLS*2*WIDTH-1:0]  matrix,
   output logic [7:0]                    transmit_byte,
   input  logic                          transmit_available,
   output logic                          transmit_ready,
   output logic                          busy,
   output logic                          done
);

   import matrix_pkg::*;

   localparam int N_DATA = ROWS * COLS * 2 * BYTES_PER_NUM;
`ifdef MATRIX_TX_CHECKSUM_EN
   localparam int N_TOTAL = N_DATA + 1;
`else
   localparam int N_TOTAL = N_DATA;
`endif
   localparam int               IDX_W    = $clog2(N_TOTAL + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TOTAL - 1);

   tx_state_t                      state;
   tx_state_t                      state_nxt;
   logic [IDX_W-1:0]               byte_idx;
   logic [ROWS*COLS*2*WIDTH-1:0]   mat_q;
   logic [7:0]                     mux_byte;
   logic [7:0]                     send_byte;
   logic                           accept;
   logic                           capture;

   assign capture = (state == ST_IDLE) && start;
   assign accept  = (state == ST_SEND) && transmit_available && !reset;

   matrix_byte_mux #(
      .ROWS          (ROWS),
      .COLS          (COLS),
      .WIDTH         (WIDTH),
      .BYTES_PER_NUM (BYTES_PER_NUM),
      .IDX_W         (IDX_W)
   ) u_byte_mux (
      .byte_idx  (byte_idx),
      .matrix    (mat_q),
      .data_byte (mux_byte)
   );

`ifdef MATRIX_TX_CHECKSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         csum_q <= '0;
      end else if (capture) begin
         csum_q <= '0;
      end else if (accept && (byte_idx != LAST_IDX)) begin
         csum_q <= csum_q ^ mux_byte;
      end
   end

   assign send_byte = (byte_idx == LAST_IDX) ? csum_q : mux_byte;
`else
   assign send_byte = mux_byte;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         byte_idx <= '0;
         mat_q    <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            mat_q    <= matrix;
            byte_idx <= '0;
         end else if (accept) begin
            byte_idx <= byte_idx + IDX_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      transmit_ready = 1'b0;
      transmit_byte  = '0;
      busy           = 1'b0;
      done           = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            busy           = 1'b1;
            transmit_byte  = send_byte;
            transmit_ready = accept;
            if (accept) state_nxt = (byte_idx == LAST_IDX) ? ST_FINISH : ST_GAP;
         end
         ST_GAP: begin
            busy      = 1'b1;
            state_nxt = ST_SEND;
         end
         ST_FINISH: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // outputs read as idle while reset is held, even mid-stream
      if (reset) begin
         transmit_ready = 1'b0;
         transmit_byte  = '0;
         busy           = 1'b0;
         done           = 1'b0;
      end
   end

endmodule

// File: tb/tb_matrix_tx_sequencer.sv
// Directed bench for matrix_tx_sequencer with a timer-based UART model.
// Honours MATRIX_TX_CHECKSUM_EN (expects the trailing XOR byte when defined).
module tb_matrix_tx_sequencer;

   localparam int N_DATA = 40;
`ifdef MATRIX_TX_CHECKSUM_EN
   localparam int N_EXP = 41;
`else
   localparam int N_EXP = 40;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic transmit_available = 1'b0;
   logic [1:0][1:0][1:0][36:0] mat = '0;
   logic [7:0] transmit_byte;
   logic transmit_ready;
   logic busy;
   logic done;

   matrix_tx_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .matrix             (mat),
      .transmit_byte      (transmit_byte),
      .transmit_available (transmit_available),
      .transmit_ready     (transmit_ready),
      .busy               (busy),
      .done               (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [7:0] got[$];
   int pulse_cyc[$];
   int done_cnt = 0;
   int done_cyc = 0;
   int start_cyc = 0;
   int cyc = 0;
   int bad_ready = 0;
   bit pulse_prev = 1'b0;
   bit use_timer = 1'b1;
   bit avail_cmd = 1'b1;
   int timer = 0;

   logic [7:0] exp_tab [0:39] = '{
      8'hA0, 8'h99, 8'h27, 8'hA8, 8'h05,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'hA1, 8'h99, 8'h27, 8'hA8, 8'h05,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'hA2, 8'h99, 8'h27, 8'hA8, 8'h05,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h5D, 8'h66, 8'hD8, 8'h57, 8'hFA,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   // monitor: records every handshake and done pulse with its cycle number
   initial forever begin
      @(negedge clk);
      cyc++;
      if (start) start_cyc = cyc;
      if (transmit_ready) begin
         got.push_back(transmit_byte);
         pulse_cyc.push_back(cyc);
         if (!transmit_available) bad_ready++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      pulse_prev = transmit_ready;
   end

   // UART model: busy for 7 cycles after each accepted byte, optional hold-off
   initial forever begin
      @(posedge clk);
      #1;
      if (use_timer && pulse_prev) timer = 7;
      if (timer > 0) begin
         transmit_available = 1'b0;
         timer--;
      end else begin
         transmit_available = avail_cmd;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      got.delete();
      pulse_cyc.delete();
      done_cnt  = 0;
      bad_ready = 0;
   endtask

   task automatic load_test_matrix();
      mat = '0;
      mat[0][0][0] = 37'd24296004000;
      mat[0][1][0] = 37'd24296004001;
      mat[1][0][0] = 37'd24296004002;
      mat[1][1][0] = -37'sd24296004003;
   endtask

   task automatic pulse_start();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) break;
         sample();
      end
      ok = (done_cnt > 0);
   endtask

   task automatic wait_pulses(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget; i++) begin
         if (got.size() >= n) break;
         sample();
      end
      ok = (got.size() >= n);
   endtask

   function automatic logic [7:0] model_csum();
      logic [7:0] x = 8'h00;
      for (int i = 0; i < N_DATA; i++) x ^= exp_tab[i];
      return x;
   endfunction

   task automatic test_reset();
      step();
      reset = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++;
         if ({transmit_ready, busy, done, transmit_byte} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: ready=%b busy=%b done=%b byte=%h, expected all 0",
                     i, transmit_ready, busy, done, transmit_byte);
         end
      end
      step();
      reset = 1'b0;
      start = 1'b0;
      repeat (5) sample();
      checks++;
      if (got.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_pulse: pulses=%0d busy=%b, expected 0 and 0", got.size(), busy);
      end
   endtask

   task automatic test_full_stream();
      bit ok;
      load_test_matrix();
      use_timer = 1'b1;
      avail_cmd = 1'b1;
      step();
      clear_log();
      pulse_start();
      wait_done(1000, ok);
      repeat (5) sample();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL full_timeout: done not seen, pulses=%0d", got.size());
      end
      checks++;
      if (got.size() != N_EXP) begin
         errors++;
         $display("FAIL full_count: got %0d bytes, expected %0d", got.size(), N_EXP);
      end
      for (int i = 0; i < N_DATA && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_tab[i]) begin
            errors++;
            $display("FAIL full_byte[%0d]: got %h, expected %h", i, got[i], exp_tab[i]);
         end
      end
`ifdef MATRIX_TX_CHECKSUM_EN
      checks++;
      if (got.size() > N_DATA && got[N_DATA] !== model_csum()) begin
         errors++;
         $display("FAIL full_csum: got %h, expected %h", got[N_DATA], model_csum());
      end
`endif
      checks++;
      if (done_cnt != 1 || bad_ready != 0) begin
         errors++;
         $display("FAIL full_done: done_cnt=%0d ready_without_avail=%0d, expected 1 and 0",
                  done_cnt, bad_ready);
      end
   endtask

   task automatic test_back_pressure();
      bit ok;
      logic [7:0] ref_byte;
      int moved, pulses_before;
      load_test_matrix();
      step();
      clear_log();
      pulse_start();
      wait_pulses(12, 1000, ok);
      step();
      avail_cmd = 1'b0;
      repeat (3) sample();
      ref_byte = transmit_byte;
      pulses_before = got.size();
      checks++;
      if (ref_byte !== exp_tab[12] || busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_held_byte: got %h busy=%b, expected %h busy=1", ref_byte, busy, exp_tab[12]);
      end
      moved = 0;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (transmit_byte !== ref_byte || transmit_ready !== 1'b0) moved++;
      end
      checks++;
      if (moved != 0 || got.size() != pulses_before) begin
         errors++;
         $display("FAIL bp_stall: unstable cycles=%0d pulses %0d->%0d, expected 0 and no change",
                  moved, pulses_before, got.size());
      end
      step();
      avail_cmd = 1'b1;
      wait_done(1000, ok);
      repeat (3) sample();
      checks++;
      if (!ok || got.size() != N_EXP) begin
         errors++;
         $display("FAIL bp_resume_count: done=%0d bytes=%0d, expected 1 and %0d", done_cnt, got.size(), N_EXP);
      end
      for (int i = 10; i < 16 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_tab[i]) begin
            errors++;
            $display("FAIL bp_byte[%0d]: got %h, expected %h", i, got[i], exp_tab[i]);
         end
      end
   endtask

   task automatic test_ignored_inputs();
      bit ok;
      int bad;
      load_test_matrix();
      step();
      clear_log();
      pulse_start();
      wait_pulses(5, 1000, ok);
      step();
      start = 1'b1;
      mat   = '1;
      step();
      start = 1'b0;
      wait_pulses(20, 1000, ok);
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(1000, ok);
      load_test_matrix();
      repeat (20) sample();
      checks++;
      if (!ok || done_cnt != 1 || got.size() != N_EXP || busy !== 1'b0) begin
         errors++;
         $display("FAIL ign_single_done: done_cnt=%0d bytes=%0d busy=%b, expected 1, %0d, 0",
                  done_cnt, got.size(), busy, N_EXP);
      end
      bad = 0;
      for (int i = 0; i < N_DATA && i < got.size(); i++)
         if (got[i] !== exp_tab[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ign_sequence: %0d bytes differ, expected 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      load_test_matrix();
      step();
      clear_log();
      pulse_start();
      wait_pulses(18, 1000, ok);
      step();
      reset = 1'b1;
      sample();
      checks++;
      if (transmit_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_during: ready=%b busy=%b, expected 0 0", transmit_ready, busy);
      end
      step();
      reset = 1'b0;
      sample();
      checks++;
      if ({transmit_ready, busy, done, transmit_byte} !== 11'd0) begin
         errors++;
         $display("FAIL rst_mid_idle: ready=%b busy=%b done=%b byte=%h, expected all 0",
                  transmit_ready, busy, done, transmit_byte);
      end
      repeat (20) sample();
      checks++;
      if (got.size() != 18 || done_cnt != 0) begin
         errors++;
         $display("FAIL rst_mid_abandon: bytes=%0d done_cnt=%0d, expected 18 and 0", got.size(), done_cnt);
      end
      step();
      clear_log();
      pulse_start();
      wait_pulses(1, 200, ok);
      checks++;
      if (!ok || got[0] !== 8'hA0) begin
         errors++;
         $display("FAIL rst_restart_first: got %h (ok=%0d), expected a0", ok ? got[0] : 8'h00, ok);
      end
      wait_done(1000, ok);
      repeat (3) sample();
      checks++;
      if (!ok || got.size() != N_EXP) begin
         errors++;
         $display("FAIL rst_restart_count: bytes=%0d, expected %0d", got.size(), N_EXP);
      end
   endtask

   task automatic test_always_available();
      bit ok;
      int bad;
      use_timer = 1'b0;
      avail_cmd = 1'b1;
      load_test_matrix();
      repeat (10) step();
      clear_log();
      pulse_start();
      wait_done(400, ok);
      repeat (3) sample();
      checks++;
      if (!ok || got.size() != N_EXP) begin
         errors++;
         $display("FAIL aa_count: bytes=%0d, expected %0d", got.size(), N_EXP);
      end else begin
         bad = 0;
         for (int i = 1; i < N_EXP; i++)
            if (pulse_cyc[i] - pulse_cyc[i-1] != 2) bad++;
         checks++;
         if (pulse_cyc[0] != start_cyc + 1 || bad != 0) begin
            errors++;
            $display("FAIL aa_spacing: first pulse at +%0d, bad gaps=%0d, expected +1 and 0",
                     pulse_cyc[0] - start_cyc, bad);
         end
         checks++;
         if (done_cyc != start_cyc + 2 * N_EXP) begin
            errors++;
            $display("FAIL aa_done_cycle: done at +%0d, expected +%0d", done_cyc - start_cyc, 2 * N_EXP);
         end
      end
`ifdef MATRIX_TX_CHECKSUM_EN
      mat = '0;
      mat[0][0][0] = 37'd1;
      step();
      clear_log();
      pulse_start();
      wait_done(400, ok);
      repeat (3) sample();
      checks++;
      if (got.size() != N_EXP || got[0] !== 8'h01 || got[N_DATA] !== 8'h01) begin
         errors++;
         $display("FAIL aa_csum_unit: bytes=%0d first=%h last=%h, expected %0d 01 01",
                  got.size(), got.size() > 0 ? got[0] : 8'h00,
                  got.size() > N_DATA ? got[N_DATA] : 8'h00, N_EXP);
      end
`endif
      use_timer = 1'b1;
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_back_pressure();
      test_ignored_inputs();
      test_reset_mid();
      test_always_available();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
